// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer writer: FSM states,
// default resolution, address width and the queued pixel entry.
package fb_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    FINISH
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [RGB_W-1:0]  rgb;
  } pix_entry_t;

  // Event counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO. A newly pushed entry becomes visible to the reader one
// cycle after the push (no fall-through); count_c reflects pushes immediately.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data_c,
  output logic                   rd_avail_c,
  output logic [$clog2(DEPTH):0] count_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_seen;

  // Storage carries no reset; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wr_ptr_seen <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr_seen <= wr_ptr;
    end
  end

  assign count_c    = wr_ptr - rd_ptr;
  assign rd_avail_c = (rd_ptr != wr_ptr_seen);
  assign rd_data_c  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/framebuffer_writer.sv
// Buffers shader pixels, converts coordinates to linear word addresses and
// issues them as acknowledged memory writes; signals completion per triangle.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_pixel,
  input  logic [15:0]       x_pixel,
  input  logic [15:0]       y_pixel,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  input  logic              done,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RGB_W-1:0]  mem_data,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic [CNT_W-1:0]  clip_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state, state_n;
  logic             pending_done;
  logic             in_range, push, pop, clip, drop;
  logic             fifo_avail;
  logic [PTR_W-1:0] fifo_count;
  pix_entry_t       wr_entry, head;

  assign in_range = (32'(x_pixel) < H_RES) && (32'(y_pixel) < V_RES);
  assign clip     = write_pixel && !in_range;
  assign drop     = write_pixel && in_range && !in_ready;
  assign push     = write_pixel && in_range && in_ready;

  // H_RES is a constant, so this reduces to shifts and adds.
  assign wr_entry.addr = ADDR_W'(32'(y_pixel) * H_RES + 32'(x_pixel));
  assign wr_entry.rgb  = {R, G, B};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wr_data    (wr_entry),
    .pop        (pop),
    .rd_data_c  (head),
    .rd_avail_c (fifo_avail),
    .count_c    (fifo_count)
  );

  // Next state; FINISH waits for true emptiness so a just-pushed pixel is not skipped.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_avail) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end else if (pending_done && (fifo_count == '0)) begin
          state_n = FINISH;
        end
      end
      ISSUE:    state_n = mem_ack ? IDLE : WAIT_ACK;
      WAIT_ACK: if (mem_ack) state_n = IDLE;
      FINISH:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_we       <= 1'b0;
      frame_done   <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      pending_done <= 1'b0;
      in_ready     <= 1'b1;
      clip_count   <= '0;
      drop_count   <= '0;
    end else begin
      state      <= state_n;
      mem_we     <= (state_n == ISSUE) || (state_n == WAIT_ACK);
      frame_done <= (state_n == FINISH);
      in_ready   <= (32'(fifo_count) + 32'(push) - 32'(pop)) < FIFO_DEPTH;
      if (pop) begin
        mem_addr <= head.addr;
        mem_data <= head.rgb;
      end
      if (state == FINISH) pending_done <= 1'b0;
      else if (done)       pending_done <= 1'b1;
      if (clip) clip_count <= sat_inc(clip_count);
      if (drop) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer with hand-computed expectations.
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        reset, write_pixel, done, mem_ack;
  logic [15:0] x_pixel, y_pixel;
  logic [7:0]  R, G, B;
  logic        in_ready, mem_we, frame_done;
  logic [18:0] mem_addr;
  logic [23:0] mem_data;
  logic [15:0] clip_count, drop_count;

  int total = 0;
  int bad   = 0;

  framebuffer_writer dut (
    .clk         (clk),
    .reset       (reset),
    .write_pixel (write_pixel),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .R           (R),
    .G           (G),
    .B           (B),
    .done        (done),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .frame_done  (frame_done),
    .clip_count  (clip_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] rgb);
    write_pixel = 1'b1;
    x_pixel     = 16'(x);
    y_pixel     = 16'(y);
    {R, G, B}   = rgb;
  endtask

  initial begin
    // Reset with live-looking inputs that must be ignored
    reset = 1'b1; mem_ack = 1'b1; done = 1'b1;
    pix(1, 1, 24'h123456);
    tick(); tick();
    reset = 1'b0; done = 1'b0; write_pixel = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data", 32'(mem_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_clip", 32'(clip_count), 0);
    chk("rst_drop", 32'(drop_count), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_quiet_we", 32'(mem_we), 0);
      chk("rst_quiet_fd", 32'(frame_done), 0);
    end

    // Single pixel, ack tied high: latency E+2, one-cycle write
    pix(3, 2, 24'h0A141E); tick(); write_pixel = 1'b0;
    chk("single_e0_we", 32'(mem_we), 0);
    tick(); chk("single_e1_we", 32'(mem_we), 0);
    tick();
    chk("single_e2_we", 32'(mem_we), 1);
    chk("single_addr", 32'(mem_addr), 1283);
    chk("single_data", 32'(mem_data), 32'h0A141E);
    tick();
    chk("single_e3_we", 32'(mem_we), 0);
    chk("single_in_ready", 32'(in_ready), 1);

    // Ack withheld five cycles: mem_we high six cycles, payload stable
    mem_ack = 1'b0;
    pix(5, 0, 24'h010203); tick(); write_pixel = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_we", 32'(mem_we), 1);
      chk("hold_addr", 32'(mem_addr), 5);
      chk("hold_data", 32'(mem_data), 32'h010203);
      tick();
    end
    mem_ack = 1'b1;
    chk("hold_last_we", 32'(mem_we), 1);
    chk("hold_last_addr", 32'(mem_addr), 5);
    tick();
    chk("hold_release_we", 32'(mem_we), 0);

    // Clipping at the coordinate boundaries
    pix(640, 0, 24'h111111); tick();
    pix(0, 480, 24'h222222); tick();
    pix(639, 479, 24'hFFEEDD); tick(); write_pixel = 1'b0;
    chk("clip_count2", 32'(clip_count), 2);
    chk("clip_e0_we", 32'(mem_we), 0);
    tick(); chk("clip_e1_we", 32'(mem_we), 0);
    tick();
    chk("clip_e2_we", 32'(mem_we), 1);
    chk("clip_addr", 32'(mem_addr), 307199);
    chk("clip_data", 32'(mem_data), 32'hFFEEDD);
    tick();
    chk("clip_e3_we", 32'(mem_we), 0);
    chk("clip_drop0", 32'(drop_count), 0);

    // Back-to-back pixels against a stalled memory
    mem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix(i, 1, {8'(i), 16'hAA55});
      tick();
      if (i == 7) chk("full_ready_before", 32'(in_ready), 1);
      if (i == 8) chk("full_ready_after", 32'(in_ready), 0);
    end
    chk("full_drop1", 32'(drop_count), 1);
    pix(700, 1, 24'h000000); tick(); write_pixel = 1'b0;
    chk("full_clip_prio_clip", 32'(clip_count), 3);
    chk("full_clip_prio_drop", 32'(drop_count), 1);
    chk("full_inflight_we", 32'(mem_we), 1);
    chk("full_inflight_addr", 32'(mem_addr), 640);
    chk("full_inflight_data", 32'(mem_data), 32'h00AA55);
    chk("full_ready_low", 32'(in_ready), 0);
    mem_ack = 1'b1;
    for (int j = 1; j < 9; j++) begin
      tick(); chk("drain_gap_we", 32'(mem_we), 0);
      tick();
      chk("drain_we", 32'(mem_we), 1);
      chk("drain_addr", 32'(mem_addr), 32'(640 + j));
      chk("drain_data", 32'(mem_data), {8'h00, 8'(j), 16'hAA55});
    end
    tick(); chk("drain_end_we", 32'(mem_we), 0);
    tick(); tick();
    chk("drain_quiet_we", 32'(mem_we), 0);
    chk("drain_ready", 32'(in_ready), 1);

    // done with three pixels queued and delayed acks
    mem_ack = 1'b0;
    pix(0, 3, 24'h000001); tick();
    pix(1, 3, 24'h000002); tick();
    pix(2, 3, 24'h000003); done = 1'b1; tick();
    write_pixel = 1'b0; done = 1'b0;
    chk("done_p0_we", 32'(mem_we), 1);
    chk("done_p0_addr", 32'(mem_addr), 1920);
    chk("done_p0_fd", 32'(frame_done), 0);
    done = 1'b1; tick(); done = 1'b0;
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("done_ack0_fd", 32'(frame_done), 0);
    tick();
    chk("done_p1_we", 32'(mem_we), 1);
    chk("done_p1_addr", 32'(mem_addr), 1921);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("done_ack1_fd", 32'(frame_done), 0);
    tick();
    chk("done_p2_addr", 32'(mem_addr), 1922);
    tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("done_ack2_we", 32'(mem_we), 0);
    chk("done_ack2_fd", 32'(frame_done), 0);
    tick();
    chk("done_pulse", 32'(frame_done), 1);
    chk("done_pulse_we", 32'(mem_we), 0);
    tick(); chk("done_after1", 32'(frame_done), 0);
    tick(); chk("done_after2", 32'(frame_done), 0);

    // Pixel and done on the same edge: pixel written before frame_done
    mem_ack = 1'b1;
    pix(4, 0, 24'h0000AA); done = 1'b1; tick();
    write_pixel = 1'b0; done = 1'b0;
    chk("same_e0_fd", 32'(frame_done), 0);
    tick();
    chk("same_e1_fd", 32'(frame_done), 0);
    chk("same_e1_we", 32'(mem_we), 0);
    tick();
    chk("same_e2_we", 32'(mem_we), 1);
    chk("same_e2_addr", 32'(mem_addr), 4);
    chk("same_e2_fd", 32'(frame_done), 0);
    tick();
    chk("same_e3_we", 32'(mem_we), 0);
    chk("same_e3_fd", 32'(frame_done), 0);
    tick(); chk("same_pulse", 32'(frame_done), 1);
    tick(); chk("same_after", 32'(frame_done), 0);

    // Reset during WAIT_ACK with four queued
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix(10 + i, 0, 24'h0F0F0F);
      tick();
    end
    write_pixel = 1'b0;
    chk("prerst_we", 32'(mem_we), 1);
    chk("prerst_addr", 32'(mem_addr), 10);
    reset = 1'b1; done = 1'b1;
    pix(20, 0, 24'h777777);
    tick();
    chk("midrst_we", 32'(mem_we), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_clip", 32'(clip_count), 0);
    chk("midrst_drop", 32'(drop_count), 0);
    chk("midrst_addr", 32'(mem_addr), 0);
    chk("midrst_fd", 32'(frame_done), 0);
    reset = 1'b0; done = 1'b0; write_pixel = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_we", 32'(mem_we), 0);
      chk("postrst_fd", 32'(frame_done), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
